// File: rtl/uart_loader.sv
// UART-fed payload loader: 8N1 receiver plus a header/payload/checksum transfer FSM.
// Define UART_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the payload.
`timescale 1ns/1ps

module uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       UART_RX,
    output logic [7:0] loader_data,
    output logic       loader_ready,
    output logic       loader_enable,
    output logic       loader_done,
    output logic       frame_err,
    output logic       checksum_err,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE} state_e;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = CSUM;
`else
    localparam state_e AFTER_DATA = DONE;
`endif

    // ---------------- receiver ----------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    // NOTE: synchronizer flops reset to 1 so a reset release never looks like a start edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) byte_valid_d = 1'b1;
                    else           frame_err_d  = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ---------------- transfer FSM ----------------
    state_e                 state_q, state_d;
    logic [23:0]            hdr_q, hdr_d;
    logic [1:0]             hdr_cnt_q, hdr_cnt_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [7:0]             data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   enable_q, enable_d;
    logic                   done_q, done_d;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
    logic       cerr_q, cerr_d;
`endif

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        hdr_cnt_d  = hdr_cnt_q;
        words_d    = words_q;
        byte_idx_d = byte_idx_q;
        data_d     = data_q;
        ready_d    = 1'b0;
        enable_d   = enable_q;
        done_d     = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        xor_d  = xor_q;
        cerr_d = cerr_q;
`endif
        // The final pulse is the only one seen after leaving DATA; enable drops right behind it.
        if (ready_q && state_q != DATA) enable_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_valid_q) begin
                    hdr_d     = {shift_q, hdr_q[23:8]};
                    hdr_cnt_d = 2'd1;
                    state_d   = HDR;
`ifdef UART_LOADER_CHECKSUM_EN
                    xor_d = '0;
`endif
                end
            end
            HDR: begin
                if (byte_valid_q) begin
                    hdr_d     = {shift_q, hdr_q[23:8]};
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        words_d    = COUNT_WIDTH'({shift_q, hdr_q});
                        byte_idx_d = '0;
                        if (words_d != '0) begin
                            state_d  = DATA;
                            enable_d = 1'b1;
                        end else begin
                            state_d = AFTER_DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (byte_valid_q) begin
                    data_d     = shift_q;
                    ready_d    = 1'b1;
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ shift_q;
`endif
                    if (byte_idx_q == 2'd3) begin
                        words_d = words_q - 1'b1;
                        if (words_q == COUNT_WIDTH'(1)) state_d = AFTER_DATA;
                    end
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            CSUM: begin
                if (byte_valid_q) begin
                    if (shift_q != xor_q) cerr_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            hdr_q      <= '0;
            hdr_cnt_q  <= '0;
            words_q    <= '0;
            byte_idx_q <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            enable_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            hdr_cnt_q  <= hdr_cnt_d;
            words_q    <= words_d;
            byte_idx_q <= byte_idx_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            enable_q   <= enable_d;
            done_q     <= done_d;
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            xor_q  <= '0;
            cerr_q <= 1'b0;
        end else begin
            xor_q  <= xor_d;
            cerr_q <= cerr_d;
        end
    end
    assign checksum_err = cerr_q;
`else
    assign checksum_err = 1'b0;
`endif

    assign loader_data   = data_q;
    assign loader_ready  = ready_q;
    assign loader_enable = enable_q;
    assign loader_done   = done_q;
    assign frame_err     = frame_err_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed vector table, hand-written corner sequences
// and randomized transfers checked against a transfer-level reference model.
`timescale 1ns/1ps

module tb_uart_loader;

    localparam int CPB = 16;
    localparam int CW  = 16;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       UART_RX = 1'b1;
    logic [7:0] loader_data;
    logic       loader_ready, loader_enable, loader_done;
    logic       frame_err, checksum_err, busy;

    uart_loader #(.CLKS_PER_BIT(CPB), .COUNT_WIDTH(CW)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .UART_RX      (UART_RX),
        .loader_data  (loader_data),
        .loader_ready (loader_ready),
        .loader_enable(loader_enable),
        .loader_done  (loader_done),
        .frame_err    (frame_err),
        .checksum_err (checksum_err),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // observed behaviour, collected at the falling edge
    logic [7:0] got_q[$];
    int         done_cnt, rise_cnt, proto_err;
    logic       prev_ready, prev_enable;
    logic [7:0] prev_data;

    // reference model state
    logic [7:0] src_q[$];
    bit         exp_ferr, exp_cerr;

    typedef struct {
        string       name;
        logic [31:0] hdr;
        logic [63:0] payload;   // byte i at [8*i +: 8]
        bit          corrupt;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_ready  = 1'b0;
            prev_enable = 1'b0;
            prev_data   = 8'h00;
        end else begin
            if (loader_ready) begin
                got_q.push_back(loader_data);
                if (!loader_enable || !prev_enable || prev_ready) proto_err++;
            end else if (loader_data !== prev_data) begin
                proto_err++;
            end
            if (loader_enable && !prev_enable) rise_cnt++;
            if (!loader_enable && prev_enable && !prev_ready) proto_err++;
            if (loader_done) done_cnt++;
            prev_ready  = loader_ready;
            prev_enable = loader_enable;
            prev_data   = loader_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        UART_RX = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (CPB) @(negedge CLK);
        end
        UART_RX = stop_ok;
        repeat (CPB) @(negedge CLK);
        UART_RX = 1'b1;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic clear_obs();
        got_q.delete();
        done_cnt  = 0;
        rise_cnt  = 0;
        proto_err = 0;
    endtask

    // Sends header, 4*N payload bytes from src_q (optionally a bad-stop byte before index bad_at)
    // and, in the checksum build, the XOR byte; then compares against the model.
    task automatic do_transfer(input string name, input logic [31:0] hdr, input bit corrupt,
                               input int bad_at);
        int         n;
        int         mism;
        logic [7:0] x;
        n = int'(hdr % (32'd1 << CW));
        x = 8'h00;
        clear_obs();
        for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], 1'b1);
        for (int i = 0; i < 4 * n; i++) begin
            if (i == bad_at) begin
                send_byte(8'h3C, 1'b0);
                exp_ferr = 1'b1;
            end
            send_byte(src_q[i], 1'b1);
            x = x ^ src_q[i];
        end
        if (CSUM_EN) begin
            send_byte(corrupt ? (x ^ 8'h81) : x, 1'b1);
            if (corrupt) exp_cerr = 1'b1;
        end
        repeat (4) @(negedge CLK);
        mism = 0;
        if (got_q.size() == 4 * n)
            for (int i = 0; i < 4 * n; i++) if (got_q[i] !== src_q[i]) mism++;
        check({name, " byte count"}, got_q.size(), 4 * n);
        check({name, " byte values"}, mism, 0);
        check({name, " done pulses"}, done_cnt, 1);
        check({name, " enable rises"}, rise_cnt, (n > 0) ? 1 : 0);
        check({name, " handshake"}, proto_err, 0);
        check({name, " frame_err"}, frame_err, exp_ferr);
        check({name, " checksum_err"}, checksum_err, exp_cerr);
        check({name, " idle after"}, {busy, loader_enable}, 2'b00);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   busy_seen;
        int   n;
        logic [31:0] hdr;
        int   bad;

        vecs[0] = '{"hdr1_ec",   32'h0000_0001, 64'hEC00_0000,          1'b0, 4};
        vecs[1] = '{"hdr2",      32'h0000_0002, 64'h8877_6655_4433_2211, 1'b0, 8};
        vecs[2] = '{"hdr0",      32'h0000_0000, 64'h0,                  1'b0, 0};
        vecs[3] = '{"truncated", 32'h0001_0001, 64'hF00F_5AA5,          1'b0, 4};
        vecs[4] = '{"bad_csum",  32'h0000_0002, 64'h0102_0408_1020_4080, 1'b1, 8};

        exp_ferr = 1'b0;
        exp_cerr = 1'b0;
        clear_obs();

        repeat (3) @(negedge CLK);
        check("reset outputs",
              {loader_data, loader_ready, loader_enable, loader_done, frame_err, checksum_err, busy},
              14'h0);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);

        // IDLE glitch shorter than half a bit
        clear_obs();
        busy_seen = 0;
        UART_RX = 1'b0;
        repeat (CPB / 4) @(negedge CLK);
        UART_RX = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge CLK);
            if (busy) busy_seen = 1;
        end
        check("glitch busy", busy_seen, 0);
        check("glitch bytes", got_q.size(), 0);
        check("glitch frame_err", frame_err, 1'b0);

        for (int v = 0; v < 5; v++) begin
            src_q.delete();
            for (int b = 0; b < 8; b++) src_q.push_back(vecs[v].payload[8*b +: 8]);
            do_transfer(vecs[v].name, vecs[v].hdr, vecs[v].corrupt, -1);
            check({vecs[v].name, " pulses"}, got_q.size(), vecs[v].exp_pulses);
        end

        // framing error in the middle of DATA
        src_q.delete();
        src_q.push_back(8'h10); src_q.push_back(8'h20); src_q.push_back(8'h30); src_q.push_back(8'h40);
        do_transfer("frame_err", 32'h1, 1'b0, 2);

        // reset after 5 of 8 payload bytes
        src_q.delete();
        for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
        clear_obs();
        for (int k = 0; k < 4; k++) send_byte((k == 0) ? 8'h02 : 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(src_q[i], 1'b1);
        check("pre-reset enable", loader_enable, 1'b1);
        check("pre-reset bytes", got_q.size(), 5);
        RST_N = 1'b0;
        #1;
        check("reset drops enable", {loader_enable, busy}, 2'b00);
        repeat (3) @(negedge CLK);
        check("reset no done", done_cnt, 0);
        check("reset clears flags", {frame_err, checksum_err}, 2'b00);
        RST_N = 1'b1;
        exp_ferr = 1'b0;
        exp_cerr = 1'b0;
        repeat (3) @(negedge CLK);
        do_transfer("after reset", 32'h2, 1'b0, -1);

        // randomized transfers, upper header bits exercise truncation
        for (int r = 0; r < 3; r++) begin
            n   = $urandom_range(0, 3);
            hdr = ($urandom & 32'hFFFF_0000) | 32'(n);
            bad = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4 * n - 1)) : -1;
            src_q.delete();
            for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
            do_transfer("random", hdr, $urandom_range(0, 1) == 1, bad);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
